// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM for the RV32I core
module core_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_instr,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             reg_wr_en,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instret
);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

  state_t        state;
  state_t        fetch_nxt;
  logic          armed;
  logic [WW-1:0] wait_cnt;
  logic          is_ld, is_st, is_br, legal, expired;

  // opcode class decode plus Mealy strobe generation from the state register
  always_comb begin
    is_ld         = opcode == 7'b0000011;
    is_st         = opcode == 7'b0100011;
    is_br         = opcode == 7'b1100011;
    legal         = is_ld || is_st || is_br || opcode == 7'b0110011 || opcode == 7'b0010011;
    fetch_nxt     = halt_req ? HALT : FETCH;
    mem_req       = state == FETCH || state == MEM;
    mem_sel_instr = state == FETCH;
    mem_we        = state == MEM && is_st;
    expired       = mem_req && !mem_ready && wait_cnt == WW'(TIMEOUT - 1);
    ir_en         = state == FETCH && mem_ready;
    pc_en         = (state == EXECUTE && is_br) || (state == MEM && is_st && mem_ready) || state == WB;
    pc_sel_branch = state == EXECUTE && is_br && branch_taken;
    reg_wr_en     = state == WB;
    halted        = state == HALT;
  end

  // state sequencing, memory wait counter, halt cause and retirement count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      armed    <= 1'b0;
      wait_cnt <= '0;
      err      <= 2'b00;
      instret  <= '0;
    end else begin
      armed    <= 1'b1;
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1'b1 : '0;
      if (pc_en) instret <= instret + 1'b1;
      case (state)
        IDLE:    if (armed) state <= fetch_nxt;
        FETCH:   if (mem_ready) state <= DECODE;
                 else if (expired) begin
                   state <= HALT;
                   err   <= 2'b10;
                 end
        DECODE:  if (legal) state <= EXECUTE;
                 else begin
                   state <= HALT;
                   err   <= 2'b01;
                 end
        EXECUTE: state <= is_br ? fetch_nxt : (is_ld || is_st) ? MEM : WB;
        MEM:     if (mem_ready) state <= is_st ? fetch_nxt : WB;
                 else if (expired) begin
                   state <= HALT;
                   err   <= 2'b10;
                 end
        WB:      state <= fetch_nxt;
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed per-cycle stimulus with a queued scoreboard checked at the falling edge
module tb_core_sequencer;
  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
  logic       mem_req, mem_we, mem_sel_instr, ir_en, pc_en, pc_sel_branch, reg_wr_en, halted;
  logic [1:0] err;
  logic [7:0] instret;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011, BAD = 7'b1111111;
  // strobe patterns: mem_req mem_we mem_sel_instr ir_en pc_en pc_sel_branch reg_wr_en halted
  localparam logic [7:0] ZERO = 8'b00000000, FW = 8'b10100000, FR = 8'b10110000, WBK = 8'b00001010,
                         BT = 8'b00001100, BN = 8'b00001000, ML = 8'b10000000, SW = 8'b11000000,
                         SR = 8'b11001000, HLT = 8'b00000001;

  typedef struct {logic [17:0] v; string nm;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  core_sequencer #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .halt_req(halt_req), .mem_req(mem_req), .mem_we(mem_we), .mem_sel_instr(mem_sel_instr),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .reg_wr_en(reg_wr_en),
    .halted(halted), .err(err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [6:0] op, input logic bt, input logic mr, input logic hr,
                     input logic [7:0] o, input logic [1:0] e, input logic [7:0] c, input string nm);
    @(posedge clk);
    #1;
    opcode = op;
    branch_taken = bt;
    mem_ready = mr;
    halt_req = hr;
    q.push_back('{{o, e, c}, nm});
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    mem_ready = 1'b0;
    halt_req = 1'b0;
    q.push_back('{18'd0, {nm, "_low"}});
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    q.push_back('{18'd0, {nm, "_rel"}});
    cyc(R, 0, 1, 0, ZERO, 2'b00, 8'd0, {nm, "_idle"});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t x;
        logic [17:0] a;
        x = q.pop_front();
        a = {mem_req, mem_we, mem_sel_instr, ir_en, pc_en, pc_sel_branch, reg_wr_en, halted, err, instret};
        total++;
        if (a !== x.v) begin
          bad++;
          $display("FAIL %s: got %b_%b_%0d required %b_%b_%0d", x.nm, a[17:10], a[9:8], a[7:0], x.v[17:10], x.v[9:8], x.v[7:0]);
        end
      end
    end
  end

  initial begin
    do_reset("rst0");
    cyc(R, 0, 1, 0, FR,   2'b00, 8'd0, "r_fetch");
    cyc(R, 0, 1, 0, ZERO, 2'b00, 8'd0, "r_dec");
    cyc(R, 0, 1, 0, ZERO, 2'b00, 8'd0, "r_exe");
    cyc(R, 0, 1, 0, WBK,  2'b00, 8'd0, "r_wb");
    cyc(I, 0, 1, 0, FR,   2'b00, 8'd1, "i_fetch");
    cyc(I, 0, 1, 0, ZERO, 2'b00, 8'd1, "i_dec");
    cyc(I, 0, 1, 0, ZERO, 2'b00, 8'd1, "i_exe");
    cyc(I, 0, 1, 0, WBK,  2'b00, 8'd1, "i_wb");
    cyc(LD, 0, 0, 0, FW,  2'b00, 8'd2, "ld_fw0");
    cyc(LD, 0, 0, 0, FW,  2'b00, 8'd2, "ld_fw1");
    cyc(LD, 0, 1, 0, FR,  2'b00, 8'd2, "ld_fr");
    cyc(LD, 0, 1, 0, ZERO, 2'b00, 8'd2, "ld_dec");
    cyc(LD, 0, 1, 0, ZERO, 2'b00, 8'd2, "ld_exe");
    for (int i = 0; i < 3; i++) cyc(LD, 0, 0, 0, ML, 2'b00, 8'd2, "ld_mw");
    cyc(LD, 0, 1, 0, ML,  2'b00, 8'd2, "ld_mr");
    cyc(LD, 0, 1, 0, WBK, 2'b00, 8'd2, "ld_wb");
    cyc(ST, 0, 1, 0, FR,  2'b00, 8'd3, "st_fetch");
    cyc(ST, 0, 1, 0, ZERO, 2'b00, 8'd3, "st_dec");
    cyc(ST, 0, 1, 0, ZERO, 2'b00, 8'd3, "st_exe");
    cyc(ST, 0, 0, 0, SW,  2'b00, 8'd3, "st_mw");
    cyc(ST, 0, 1, 0, SR,  2'b00, 8'd3, "st_mr");
    cyc(BR, 1, 1, 0, FR,  2'b00, 8'd4, "bt_fetch");
    cyc(BR, 1, 1, 0, ZERO, 2'b00, 8'd4, "bt_dec");
    cyc(BR, 1, 1, 0, BT,  2'b00, 8'd4, "bt_exe");
    cyc(BR, 0, 1, 0, FR,  2'b00, 8'd5, "bn_fetch");
    cyc(BR, 0, 1, 0, ZERO, 2'b00, 8'd5, "bn_dec");
    cyc(BR, 0, 1, 0, BN,  2'b00, 8'd5, "bn_exe");
    cyc(LD, 0, 1, 0, FR,  2'b00, 8'd6, "tw_fetch");
    cyc(LD, 0, 1, 0, ZERO, 2'b00, 8'd6, "tw_dec");
    cyc(LD, 0, 1, 0, ZERO, 2'b00, 8'd6, "tw_exe");
    for (int i = 0; i < 3; i++) cyc(LD, 0, 0, 0, ML, 2'b00, 8'd6, "tw_mw");
    cyc(LD, 0, 1, 0, ML,  2'b00, 8'd6, "tw_mr4");
    cyc(LD, 0, 1, 0, WBK, 2'b00, 8'd6, "tw_wb");
    cyc(R, 0, 1, 1, FR,   2'b00, 8'd7, "hr_fetch");
    cyc(R, 0, 1, 1, ZERO, 2'b00, 8'd7, "hr_dec");
    cyc(R, 0, 1, 1, ZERO, 2'b00, 8'd7, "hr_exe");
    cyc(R, 0, 1, 1, WBK,  2'b00, 8'd7, "hr_wb");
    cyc(R, 0, 1, 0, HLT,  2'b00, 8'd8, "hr_halt");
    cyc(R, 0, 1, 0, HLT,  2'b00, 8'd8, "hr_sticky");
    do_reset("rst1");
    cyc(BAD, 0, 1, 0, FR,   2'b00, 8'd0, "il_fetch");
    cyc(BAD, 0, 1, 0, ZERO, 2'b00, 8'd0, "il_dec");
    cyc(BAD, 0, 1, 0, HLT,  2'b01, 8'd0, "il_halt");
    cyc(BAD, 0, 1, 0, HLT,  2'b01, 8'd0, "il_sticky");
    do_reset("rst2");
    cyc(ST, 0, 1, 0, FR,   2'b00, 8'd0, "to_fetch");
    cyc(ST, 0, 1, 0, ZERO, 2'b00, 8'd0, "to_dec");
    cyc(ST, 0, 1, 0, ZERO, 2'b00, 8'd0, "to_exe");
    for (int i = 0; i < 4; i++) cyc(ST, 0, 0, 0, SW, 2'b00, 8'd0, "to_mw");
    cyc(ST, 0, 1, 0, HLT,  2'b10, 8'd0, "to_halt");
    do_reset("rst3");
    for (int i = 0; i < 4; i++) cyc(R, 0, 0, 0, FW, 2'b00, 8'd0, "fto_fw");
    cyc(R, 0, 1, 0, HLT,   2'b10, 8'd0, "fto_halt");
    do_reset("rst4");
    cyc(R, 0, 1, 0, FR,   2'b00, 8'd0, "mr_fetch");
    cyc(R, 0, 1, 0, ZERO, 2'b00, 8'd0, "mr_dec");
    cyc(R, 0, 1, 0, ZERO, 2'b00, 8'd0, "mr_exe");
    cyc(R, 0, 1, 0, WBK,  2'b00, 8'd0, "mr_wb");
    cyc(LD, 0, 1, 0, FR,  2'b00, 8'd1, "mr_ldf");
    cyc(LD, 0, 1, 0, ZERO, 2'b00, 8'd1, "mr_ldd");
    cyc(LD, 0, 0, 0, ZERO, 2'b00, 8'd1, "mr_lde");
    do_reset("midmem");
    cyc(R, 0, 0, 0, FW,   2'b00, 8'd0, "post_rst_fetch");
    do_reset("rst5");
    for (int i = 0; i < 256; i++) begin
      cyc(BR, 0, 1, 0, FR,   2'b00, 8'(i), "wr_fetch");
      cyc(BR, 0, 1, 0, ZERO, 2'b00, 8'(i), "wr_dec");
      cyc(BR, 0, 1, 0, BN,   2'b00, 8'(i), "wr_exe");
    end
    cyc(R, 0, 0, 0, FW,   2'b00, 8'd0, "wrap");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
